// File: rtl/pkt_crc_checker.sv
// Byte-serial packet receiver: hunts for HEADER, assembles a DATA_BYTES payload, checks its CRC-16.
// Optional build macro PKTCHK_DROP_BAD_EN: packets failing the CRC check are dropped instead of presented.
module pkt_crc_checker #(
    parameter int          DATA_BYTES = 9,
    parameter logic [7:0]  HEADER     = 8'h3C,
    parameter logic [15:0] POLY       = 16'h1021,
    parameter logic [15:0] CRC_INIT   = 16'h0000
) (
    input  logic                    clk,
    input  logic                    reset_L,
    input  logic                    in_valid,
    input  logic [7:0]              in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_BYTES*8-1:0] out_data,
    output logic                    out_err,
    output logic [7:0]              err_cnt
);

    localparam int DATA_W = DATA_BYTES * 8;
    localparam int CNT_W  = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_BYTES - 1);

    typedef enum logic [2:0] {
        S_HUNT,
        S_DATA,
        S_CRC_HI,
        S_CRC_LO,
        S_OUT
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  byte_cnt;
    logic [15:0]       crc;
    logic [7:0]        rx_crc_hi;
    logic [DATA_W-1:0] payload;
    logic              byte_fire;
    logic              crc_bad;

    // Folds one byte into the CRC, MSB first, eight bit-steps in a single cycle.
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[15] ^ b[i];
            r  = {r[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
        end
        return r;
    endfunction

    assign in_ready  = (state != S_OUT);
    assign out_valid = (state == S_OUT);
    assign out_data  = payload;
    assign byte_fire = in_valid && in_ready;
    assign crc_bad   = ({rx_crc_hi, in_data} != crc);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_L) state <= S_HUNT;
        else          state <= state_nxt;
    end

    // NOTE: next state defaults to the current state first, so no path through the case infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_HUNT:   if (byte_fire && in_data == HEADER)  state_nxt = S_DATA;
            S_DATA:   if (byte_fire && byte_cnt == LAST_IDX) state_nxt = S_CRC_HI;
            S_CRC_HI: if (byte_fire) state_nxt = S_CRC_LO;
            S_CRC_LO: begin
                if (byte_fire) begin
`ifdef PKTCHK_DROP_BAD_EN
                    state_nxt = crc_bad ? S_HUNT : S_OUT;
`else
                    state_nxt = S_OUT;
`endif
                end
            end
            S_OUT:    if (out_ready) state_nxt = S_HUNT;
            default:  state_nxt = S_HUNT;
        endcase
    end

    // Payload is reset too: the consumer sees out_data = 0 after reset, not stale bytes.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            byte_cnt  <= '0;
            crc       <= CRC_INIT;
            rx_crc_hi <= 8'h00;
            payload   <= '0;
            out_err   <= 1'b0;
            err_cnt   <= 8'h00;
        end else if (byte_fire) begin
            case (state)
                S_HUNT: begin
                    if (in_data == HEADER) begin
                        byte_cnt <= '0;
                        crc      <= CRC_INIT;
                    end
                end
                S_DATA: begin
                    payload  <= (payload << 8) | DATA_W'(in_data);
                    crc      <= crc_step(crc, in_data);
                    byte_cnt <= byte_cnt + 1'b1;
                end
                S_CRC_HI: rx_crc_hi <= in_data;
                S_CRC_LO: begin
`ifdef PKTCHK_DROP_BAD_EN
                    out_err <= 1'b0;
`else
                    out_err <= crc_bad;
`endif
                    if (crc_bad && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_crc_checker.sv
// Self-checking bench for pkt_crc_checker: directed scenarios plus randomized traffic against a
// packet-level reference model (CRC by polynomial long division over the whole message).
module tb_pkt_crc_checker;

    localparam int          DB       = 9;
    localparam int          DW       = DB * 8;
    localparam logic [7:0]  HEADER   = 8'h3C;
    localparam logic [15:0] POLY     = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'h0000;
    localparam logic [16:0] GEN      = {1'b1, POLY};
    localparam logic [DW-1:0] GOOD_DATA = 72'h313233343536373839;

    logic          clk = 1'b0;
    logic          reset_L;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_err;
    logic [7:0]    err_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit            m_in_pkt = 1'b0;
    logic [7:0]    m_buf[$];
    bit            m_pend   = 1'b0;
    logic [DW-1:0] m_data   = '0;
    bit            m_err    = 1'b0;
    int            m_errcnt = 0;
    bit            m_accepted = 1'b0;

    pkt_crc_checker #(
        .DATA_BYTES(DB),
        .HEADER    (HEADER),
        .POLY      (POLY),
        .CRC_INIT  (CRC_INIT)
    ) dut (
        .clk      (clk),
        .reset_L  (reset_L),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_err  (out_err),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    // CRC as remainder of (message * x^16) mod G, with the init value added to the first 16 bits.
    function automatic logic [15:0] crc_ref(input logic [7:0] q[$]);
        logic [16:0] rem;
        logic        b;
        int          nmsg;
        rem  = '0;
        nmsg = q.size() * 8;
        for (int i = 0; i < nmsg + 16; i++) begin
            b = (i < nmsg) ? q[i / 8][7 - (i % 8)] : 1'b0;
            if (i < 16) b = b ^ CRC_INIT[15 - i];
            rem = {rem[15:0], b};
            if (rem[16]) rem = rem ^ GEN;
        end
        return rem[15:0];
    endfunction

    task automatic model_accept(input logic [7:0] d);
        logic [7:0]    pay[$];
        logic [15:0]   rx;
        logic [DW-1:0] data;
        bit            bad;
        if (!m_in_pkt) begin
            if (d == HEADER) begin
                m_in_pkt = 1'b1;
                m_buf.delete();
            end
        end else begin
            m_buf.push_back(d);
            if (m_buf.size() == DB + 2) begin
                pay  = m_buf[0:DB-1];
                rx   = {m_buf[DB], m_buf[DB+1]};
                bad  = (crc_ref(pay) != rx);
                data = '0;
                for (int i = 0; i < DB; i++) data = (data << 8) | DW'(pay[i]);
                m_in_pkt = 1'b0;
                if (bad && m_errcnt < 255) m_errcnt++;
`ifdef PKTCHK_DROP_BAD_EN
                if (!bad) begin
                    m_pend = 1'b1;
                    m_data = data;
                    m_err  = 1'b0;
                end
`else
                m_pend = 1'b1;
                m_data = data;
                m_err  = bad;
`endif
            end
        end
    endtask

    // Drives one cycle starting from a negedge; the model advances at the posedge; returns at the next negedge.
    task automatic cycle(input bit v, input logic [7:0] d, input bit r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        @(posedge clk);
        m_accepted = v && !m_pend;
        if (m_pend && r) m_pend = 1'b0;
        if (m_accepted) model_accept(d);
        @(negedge clk);
    endtask

    task automatic reset_cycle();
        reset_L  = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        m_in_pkt = 1'b0;
        m_buf.delete();
        m_pend   = 1'b0;
        m_errcnt = 0;
        @(negedge clk);
        reset_L = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] d, input bit r);
        int n;
        n = 0;
        do begin
            cycle(1'b1, d, r);
            n++;
        end while (!m_accepted && n < 64);
        checks++;
        if (!m_accepted) begin
            failures++;
            $display("FAIL send_byte: byte %h not accepted after %0d cycles", d, n);
        end
    endtask

    task automatic send_fixed(input logic [7:0] crc_lo, input bit r);
        logic [7:0] pk[12];
        pk = '{8'h3C, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h31, crc_lo};
        foreach (pk[i]) send_byte(pk[i], r);
    endtask

    task automatic test_reset();
        reset_cycle();
        checks += 5;
        if (in_ready !== 1'b1)  begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        if (out_data !== '0)    begin failures++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        if (out_err !== 1'b0)   begin failures++; $display("FAIL reset_out_err: got %b want 0", out_err); end
        if (err_cnt !== 8'd0)   begin failures++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
    endtask

    task automatic test_good_packet();
        send_fixed(8'hC3, 1'b1);
        checks += 4;
        if (out_valid !== 1'b1)     begin failures++; $display("FAIL good_valid: got %b want 1", out_valid); end
        if (out_data !== GOOD_DATA) begin failures++; $display("FAIL good_data: got %h want %h", out_data, GOOD_DATA); end
        if (out_err !== 1'b0)       begin failures++; $display("FAIL good_err: got %b want 0", out_err); end
        if (err_cnt !== 8'd0)       begin failures++; $display("FAIL good_err_cnt: got %0d want 0", err_cnt); end
        cycle(1'b0, 8'h00, 1'b1);
        checks += 2;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL good_valid_one_cycle: got %b want 0", out_valid); end
        if (in_ready !== 1'b1)  begin failures++; $display("FAIL good_in_ready_after: got %b want 1", in_ready); end
    endtask

    task automatic test_bad_crc();
        send_fixed(8'hC4, 1'b1);
`ifdef PKTCHK_DROP_BAD_EN
        checks += 2;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL bad_dropped_valid: got %b want 0", out_valid); end
        if (err_cnt !== 8'd1)   begin failures++; $display("FAIL bad_err_cnt: got %0d want 1", err_cnt); end
`else
        checks += 4;
        if (out_valid !== 1'b1)     begin failures++; $display("FAIL bad_valid: got %b want 1", out_valid); end
        if (out_err !== 1'b1)       begin failures++; $display("FAIL bad_err: got %b want 1", out_err); end
        if (err_cnt !== 8'd1)       begin failures++; $display("FAIL bad_err_cnt: got %0d want 1", err_cnt); end
        if (out_data !== GOOD_DATA) begin failures++; $display("FAIL bad_data: got %h want %h", out_data, GOOD_DATA); end
`endif
        cycle(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_lead_in();
        logic [7:0]  pay[$];
        logic [15:0] c;
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_fixed(8'hC3, 1'b1);
        checks += 3;
        if (out_valid !== 1'b1)     begin failures++; $display("FAIL lead_in_valid: got %b want 1", out_valid); end
        if (out_data !== GOOD_DATA) begin failures++; $display("FAIL lead_in_data: got %h want %h", out_data, GOOD_DATA); end
        if (out_err !== 1'b0)       begin failures++; $display("FAIL lead_in_err: got %b want 0", out_err); end
        cycle(1'b0, 8'h00, 1'b1);
        pay = '{8'h31, 8'h32, 8'h3C, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        c   = crc_ref(pay);
        send_byte(HEADER, 1'b1);
        foreach (pay[i]) send_byte(pay[i], 1'b1);
        send_byte(c[15:8], 1'b1);
        send_byte(c[7:0], 1'b1);
        checks += 4;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL hdr_in_payload_valid: got %b want 1", out_valid); end
        if (out_data !== 72'h31323C343536373839) begin
            failures++; $display("FAIL hdr_in_payload_data: got %h want 31323c343536373839", out_data);
        end
        if (out_err !== 1'b0)          begin failures++; $display("FAIL hdr_in_payload_err: got %b want 0", out_err); end
        if (err_cnt !== 8'(m_errcnt))  begin failures++; $display("FAIL hdr_in_payload_err_cnt: got %0d want %0d", err_cnt, m_errcnt); end
        cycle(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_backpressure();
        logic [7:0] body[11];
        send_fixed(8'hC3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, HEADER, 1'b0);
            checks += 3;
            if (out_valid !== 1'b1)     begin failures++; $display("FAIL stall_valid[%0d]: got %b want 1", i, out_valid); end
            if (out_data !== GOOD_DATA) begin failures++; $display("FAIL stall_data[%0d]: got %h want %h", i, out_data, GOOD_DATA); end
            if (in_ready !== 1'b0)      begin failures++; $display("FAIL stall_in_ready[%0d]: got %b want 0", i, in_ready); end
        end
        cycle(1'b1, HEADER, 1'b1);
        checks += 2;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL handshake_valid: got %b want 0", out_valid); end
        if (in_ready !== 1'b1)  begin failures++; $display("FAIL handshake_in_ready: got %b want 1", in_ready); end
        // The header held on the bus must be taken at the very next edge for this packet to land correctly.
        cycle(1'b1, HEADER, 1'b1);
        body = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h31, 8'hC3};
        foreach (body[i]) cycle(1'b1, body[i], 1'b1);
        checks += 3;
        if (out_valid !== 1'b1)     begin failures++; $display("FAIL second_pkt_valid: got %b want 1", out_valid); end
        if (out_data !== GOOD_DATA) begin failures++; $display("FAIL second_pkt_data: got %h want %h", out_data, GOOD_DATA); end
        if (out_err !== 1'b0)       begin failures++; $display("FAIL second_pkt_err: got %b want 0", out_err); end
        cycle(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_mid_reset();
        send_byte(HEADER, 1'b1);
        for (int i = 0; i < 5; i++) send_byte(8'h41 + 8'(i), 1'b1);
        reset_cycle();
        checks += 5;
        if (in_ready !== 1'b1)  begin failures++; $display("FAIL mid_reset_in_ready: got %b want 1", in_ready); end
        if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_valid: got %b want 0", out_valid); end
        if (out_data !== '0)    begin failures++; $display("FAIL mid_reset_data: got %h want 0", out_data); end
        if (out_err !== 1'b0)   begin failures++; $display("FAIL mid_reset_err: got %b want 0", out_err); end
        if (err_cnt !== 8'd0)   begin failures++; $display("FAIL mid_reset_err_cnt: got %0d want 0", err_cnt); end
        send_fixed(8'hC3, 1'b1);
        checks += 3;
        if (out_valid !== 1'b1)     begin failures++; $display("FAIL post_reset_valid: got %b want 1", out_valid); end
        if (out_data !== GOOD_DATA) begin failures++; $display("FAIL post_reset_data: got %h want %h", out_data, GOOD_DATA); end
        if (out_err !== 1'b0)       begin failures++; $display("FAIL post_reset_err: got %b want 0", out_err); end
        cycle(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_random();
        logic [7:0]  stream[$];
        logic [7:0]  pay[$];
        logic [7:0]  g;
        logic [15:0] c;
        int          cyc;
        bit          v;
        bit          r;
        for (int p = 0; p < 40; p++) begin
            repeat ($urandom_range(0, 2)) begin
                g = 8'($urandom);
                if (g == HEADER) g = 8'h00;
                stream.push_back(g);
            end
            stream.push_back(HEADER);
            pay.delete();
            for (int i = 0; i < DB; i++) pay.push_back(8'($urandom));
            foreach (pay[i]) stream.push_back(pay[i]);
            c = crc_ref(pay);
            if ($urandom_range(0, 3) == 0) c = c ^ 16'($urandom_range(1, 65535));
            stream.push_back(c[15:8]);
            stream.push_back(c[7:0]);
        end
        cyc = 0;
        while ((stream.size() > 0 || m_pend) && cyc < 20000) begin
            v = (stream.size() > 0) && ($urandom_range(0, 4) != 0);
            r = ($urandom_range(0, 2) != 0);
            cycle(v, v ? stream[0] : 8'h00, r);
            if (m_accepted) void'(stream.pop_front());
            cyc++;
            checks += 3;
            if (in_ready !== !m_pend)       begin failures++; $display("FAIL rand_in_ready@%0d: got %b want %b", cyc, in_ready, !m_pend); end
            if (out_valid !== m_pend)       begin failures++; $display("FAIL rand_valid@%0d: got %b want %b", cyc, out_valid, m_pend); end
            if (err_cnt !== 8'(m_errcnt))   begin failures++; $display("FAIL rand_err_cnt@%0d: got %0d want %0d", cyc, err_cnt, m_errcnt); end
            if (m_pend) begin
                checks += 2;
                if (out_data !== m_data) begin failures++; $display("FAIL rand_data@%0d: got %h want %h", cyc, out_data, m_data); end
                if (out_err !== m_err)   begin failures++; $display("FAIL rand_err@%0d: got %b want %b", cyc, out_err, m_err); end
            end
        end
        checks++;
        if (stream.size() != 0) begin
            failures++; $display("FAIL rand_drain: %0d bytes left after %0d cycles, want 0", stream.size(), cyc);
        end
    endtask

    task automatic test_err_saturation();
        reset_cycle();
        for (int k = 0; k < 256; k++) begin
            send_fixed(8'hC4, 1'b1);
            if (k == 253 || k == 254) begin
                checks++;
                if (err_cnt !== 8'(k + 1)) begin failures++; $display("FAIL sat_count[%0d]: got %0d want %0d", k, err_cnt, k + 1); end
            end
        end
        cycle(1'b0, 8'h00, 1'b1);
        checks++;
        if (err_cnt !== 8'd255) begin failures++; $display("FAIL sat_final: got %0d want 255", err_cnt); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_L   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_good_packet();
        test_bad_crc();
        test_lead_in();
        test_backpressure();
        test_mid_reset();
        test_random();
        test_err_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pkt_crc_checker.md
# pkt_crc_checker

Byte-serial successor to the combinational packet set-up stage in the endpoint data path. Receives a stream of bytes (header, payload, CRC-16), hunts for the header byte, and assembles a parametrised-length payload. It computes the CRC incrementally, one byte per cycle, and presents the payload with a CRC error flag on a valid/ready output. It sits between the endpoint's byte receiver and the downstream packet consumer.

## Interface
- `DATA_BYTES`, 9, payload length in bytes (≥1); output width is `DATA_BYTES*8`.
- `HEADER`, 8'h3C, start-of-packet byte value.
- `POLY`, 16'h1021, CRC-16 generator polynomial (normal form, x^16 implicit).
- `CRC_INIT`, 16'h0000, CRC register value at start of each packet.
- `clk`  input  1  rising-edge clock.
- `reset_L`  input  1  synchronous, active-low reset.
- `in_valid`  input  1  `in_data` carries a byte.
- `in_data`  input  8  stream byte.
- `in_ready`  output  1  block accepts a byte this cycle.
- `out_valid`  output  1  `out_data`/`out_err` valid.
- `out_ready`  input  1  consumer takes the packet.
- `out_data`  output  `DATA_BYTES*8`  payload; first received byte in the MSBs.
- `out_err`  output  1  1 = received CRC ≠ computed CRC.
- `err_cnt`  output  8  count of CRC-failed packets; saturates at 255.

## Operation
- Byte transfer occurs when `in_valid && in_ready` are both high at a rising edge. Packet transfer occurs when `out_valid && out_ready` are both high.
- States:
  - `S_HUNT`: wait for a byte equal to `HEADER`. On a match, go to `S_DATA`, clear the byte counter and load `crc = CRC_INIT`. Non-matching bytes are consumed and discarded.
  - `S_DATA`: each accepted byte shifts into the payload register. The byte is folded into the CRC, MSB-first, 8 bit steps in one cycle. Per bit: `fb = crc[15]^bit; crc = {crc[14:0],1'b0} ^ (fb ? POLY : 0)`. After byte `DATA_BYTES-1`, go to `S_CRC_HI`.
  - `S_CRC_HI`: the accepted byte is latched as the received CRC [15:8]. Go to `S_CRC_LO`.
  - `S_CRC_LO`: the accepted byte is the received CRC [7:0]. Compare against the computed CRC and register `out_err`. Increment `err_cnt` on mismatch unless it is at 255. Go to `S_OUT`.
  - `S_OUT`: `out_valid=1`. On `out_ready`, go to `S_HUNT`.
- `in_ready = (state != S_OUT)`. There is a single packet buffer, so no byte is accepted while a packet is pending.
- `out_data` and `out_err` are held stable while `out_valid` is high and not yet accepted.
- A byte equal to `HEADER` inside payload or CRC is treated as data. No resynchronisation happens mid-packet.
- `in_valid` low in any state: hold state, counter and CRC.

## Timing
- Reset (`reset_L=0` at an edge), from any state including mid-packet:
  - state `S_HUNT`, byte counter 0, CRC `CRC_INIT`.
  - `out_valid=0`, `out_data=0`, `out_err=0`, `err_cnt=0`.
  - `in_ready=1` from the first cycle after reset deasserts.
  - A partial packet is discarded.
- Throughput: one byte per cycle. A packet occupies `DATA_BYTES+3` byte transfers.
- Latency: `out_valid` rises the cycle after the CRC low byte is accepted.
- `out_valid && out_ready` at edge N: `out_valid=0` and `in_ready=1` after edge N. The next header can be accepted at edge N+1.
- `err_cnt` updates at the same edge that `out_err` is registered.

## Configuration
- `PKTCHK_DROP_BAD_EN` defined:
  - A packet with a CRC mismatch is not presented. `S_CRC_LO` goes directly to `S_HUNT` and `out_valid` stays 0.
  - `err_cnt` still increments.
  - `out_err` is always 0 when `out_valid=1`.
- Not defined: every complete packet is presented with `out_err` reflecting the check (behaviour described above).

## Test plan
- Default parameters, `out_ready=1`. Bytes 3C 31 32 33 34 35 36 37 38 39 31 C3 back-to-back. Expect `out_valid` for 1 cycle, `out_data=72'h313233343536373839`, `out_err=0`, `err_cnt=0`.
- Same packet with CRC low byte C4. Expect `out_err=1` and `err_cnt=1`. With `PKTCHK_DROP_BAD_EN`: expect no `out_valid`, and `err_cnt=1`.
- Lead-in bytes 00 FF 3C followed by the good packet body. Expect 00 and FF discarded and a correct packet output; a 3C inside the payload is still treated as data.
- Good packet with `out_ready=0` for 5 cycles:
  - `out_valid`/`out_data` held stable and `in_ready=0` for those 5 cycles.
  - A second packet is offered immediately and is accepted only after the handshake.
- Assert `reset_L=0` for 1 cycle after 5 payload bytes. Expect all outputs at reset values. A subsequent good packet is received correctly.
- Send 256 bad-CRC packets. Expect `err_cnt` to saturate at 255.
